// File: rtl/st_adapter_pkg.sv
// Shared helpers for Avalon-ST data-format adapters: width derivation, ratio
// legality, and per-beat last-slice / empty arithmetic.
package st_adapter_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit ratio_ok(input int in_sym, input int out_sym);
    return (out_sym > 0) && (in_sym >= out_sym) && ((in_sym % out_sym) == 0);
  endfunction

  // Index of the last narrow slice that carries at least one valid symbol.
  function automatic int last_slice(input bit eop, input int empty, input int in_sym,
                                    input int out_sym);
    if (!eop) return in_sym / out_sym - 1;
    return (in_sym - empty + out_sym - 1) / out_sym - 1;
  endfunction

  // Unused trailing symbols inside the final narrow slice of a packet.
  function automatic int slice_empty(input bit eop, input int empty, input int in_sym,
                                     input int out_sym);
    if (!eop) return 0;
    return (last_slice(eop, empty, in_sym, out_sym) + 1) * out_sym - (in_sym - empty);
  endfunction

endpackage

// File: rtl/st_out_stage.sv
// Registered Avalon-ST output slice: loads a new beat (or a bubble) whenever the
// downstream can take one, and holds everything stable under backpressure.
module st_out_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_valid,
  input  logic [PAYLOAD_W-1:0] src_payload,
  input  logic                 out_ready,
  output logic                 adv,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload
);

  assign adv = out_ready | ~out_valid;

  // Payload holds its last value across bubbles; only valid beats overwrite it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else if (adv) begin
      out_valid <= src_valid;
      if (src_valid) out_payload <= src_payload;
    end
  end

endmodule

// File: rtl/st_width_narrower.sv
// Avalon-ST narrower: splits each wide beat into IN_SYMBOLS/OUT_SYMBOLS narrow
// beats, symbol 0 (MSBs) first, cutting short on eop beats with trailing empty.
module st_width_narrower
  import st_adapter_pkg::*;
#(
  parameter int SYMBOL_W    = 8,
  parameter int IN_SYMBOLS  = 4,
  parameter int OUT_SYMBOLS = 1,
  parameter int CHANNEL_W   = 1,
  parameter int ERROR_W     = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic                                 in_ready,
  input  logic                                 in_valid,
  input  logic [SYMBOL_W*IN_SYMBOLS-1:0]       in_data,
  input  logic [CHANNEL_W-1:0]                 in_channel,
  input  logic [ERROR_W-1:0]                   in_error,
  input  logic                                 in_startofpacket,
  input  logic                                 in_endofpacket,
  input  logic [clog2_min1(IN_SYMBOLS)-1:0]    in_empty,
  input  logic                                 out_ready,
  output logic                                 out_valid,
  output logic [SYMBOL_W*OUT_SYMBOLS-1:0]      out_data,
  output logic [CHANNEL_W-1:0]                 out_channel,
  output logic [ERROR_W-1:0]                   out_error,
  output logic                                 out_startofpacket,
  output logic                                 out_endofpacket,
  output logic [clog2_min1(OUT_SYMBOLS)-1:0]   out_empty
);

  localparam int RATIO       = IN_SYMBOLS / OUT_SYMBOLS;
  localparam int IN_W        = SYMBOL_W * IN_SYMBOLS;
  localparam int OUT_W       = SYMBOL_W * OUT_SYMBOLS;
  localparam int IN_EMPTY_W  = clog2_min1(IN_SYMBOLS);
  localparam int OUT_EMPTY_W = clog2_min1(OUT_SYMBOLS);
  localparam int IDX_W       = clog2_min1(RATIO);
  localparam int PAYLOAD_W   = OUT_W + CHANNEL_W + ERROR_W + 2 + OUT_EMPTY_W;

  if (!ratio_ok(IN_SYMBOLS, OUT_SYMBOLS)) begin : g_ratio_check
    $error("st_width_narrower: IN_SYMBOLS must be a multiple of OUT_SYMBOLS");
  end

  logic                   a_valid;
  logic [IN_W-1:0]        a_data;
  logic [CHANNEL_W-1:0]   a_channel;
  logic [ERROR_W-1:0]     a_error;
  logic                   a_sop;
  logic                   a_eop;
  logic [IN_EMPTY_W-1:0]  a_empty;
  logic [IN_EMPTY_W-1:0]  eff_empty;
  logic [IDX_W-1:0]       idx;

  int                     last;
  logic                   is_last;
  logic                   adv;
  logic                   emit;
  logic [OUT_W-1:0]       slice;
  logic                   slice_sop;
  logic                   slice_eop;
  logic [OUT_EMPTY_W-1:0] slice_emp;
  logic [PAYLOAD_W-1:0]   src_payload;
  logic [PAYLOAD_W-1:0]   out_payload;

  always_comb begin
    eff_empty = in_endofpacket ? in_empty : '0;
    if (int'(eff_empty) > IN_SYMBOLS - 1) eff_empty = IN_EMPTY_W'(IN_SYMBOLS - 1);
  end

  assign last     = last_slice(a_eop, int'(a_empty), IN_SYMBOLS, OUT_SYMBOLS);
  assign is_last  = (int'(idx) == last);
  assign emit     = adv & a_valid;
  assign in_ready = ~a_valid | (adv & is_last);

  always_comb begin
    slice = '0;
    for (int k = 0; k < RATIO; k++)
      if (int'(idx) == k) slice = a_data[IN_W-1-k*OUT_W -: OUT_W];
  end

  assign slice_sop = a_sop & (idx == '0);
  assign slice_eop = a_eop & is_last;
  assign slice_emp = slice_eop ?
                     OUT_EMPTY_W'(slice_empty(a_eop, int'(a_empty), IN_SYMBOLS, OUT_SYMBOLS)) : '0;

  // A reloads on the same edge its last slice is handed to the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_valid   <= 1'b0;
      a_data    <= '0;
      a_channel <= '0;
      a_error   <= '0;
      a_sop     <= 1'b0;
      a_eop     <= 1'b0;
      a_empty   <= '0;
      idx       <= '0;
    end else begin
      if (emit) idx <= is_last ? '0 : idx + 1'b1;
      if (in_ready && in_valid) begin
        a_valid   <= 1'b1;
        a_data    <= in_data;
        a_channel <= in_channel;
        a_error   <= in_error;
        a_sop     <= in_startofpacket;
        a_eop     <= in_endofpacket;
        a_empty   <= eff_empty;
      end else if (emit && is_last) begin
        a_valid <= 1'b0;
      end
    end
  end

  assign src_payload = {slice, a_channel, a_error, slice_sop, slice_eop, slice_emp};

  st_out_stage #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_out_stage (
    .clk        (clk),
    .rst        (reset),
    .src_valid  (a_valid),
    .src_payload(src_payload),
    .out_ready  (out_ready),
    .adv        (adv),
    .out_valid  (out_valid),
    .out_payload(out_payload)
  );

  assign {out_data, out_channel, out_error, out_startofpacket, out_endofpacket, out_empty} =
         out_payload;

endmodule

// File: tb/tb_st_width_narrower.sv
// Bench for st_width_narrower: directed scenarios plus a randomized stream checked
// against a symbol-list model of the narrowing rules.
`timescale 1ns/1ps
module tb_st_width_narrower;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // default instance: 4 symbols -> 1 symbol
  logic        in_ready, in_valid, in_channel, in_error, in_sop, in_eop;
  logic [31:0] in_data;
  logic [1:0]  in_empty;
  logic        out_ready, out_valid, out_channel, out_error, out_sop, out_eop;
  logic [7:0]  out_data;
  logic [0:0]  out_empty;

  // second instance: 4 symbols -> 2 symbols
  logic        b_in_ready, b_in_valid, b_in_channel, b_in_error, b_in_sop, b_in_eop;
  logic [31:0] b_in_data;
  logic [1:0]  b_in_empty;
  logic        b_out_ready, b_out_valid, b_out_channel, b_out_error, b_out_sop, b_out_eop;
  logic [15:0] b_out_data;
  logic [0:0]  b_out_empty;

  st_width_narrower dut (
    .clk(clk), .reset(reset),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_channel(in_channel), .in_error(in_error),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_channel(out_channel), .out_error(out_error),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty)
  );

  st_width_narrower #(.OUT_SYMBOLS(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_ready(b_in_ready), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_channel(b_in_channel), .in_error(b_in_error),
    .in_startofpacket(b_in_sop), .in_endofpacket(b_in_eop), .in_empty(b_in_empty),
    .out_ready(b_out_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_channel(b_out_channel), .out_error(b_out_error),
    .out_startofpacket(b_out_sop), .out_endofpacket(b_out_eop), .out_empty(b_out_empty)
  );

  typedef struct {
    logic [15:0] data;
    logic        ch;
    logic        err;
    logic        sop;
    logic        eop;
    logic        emp;
    logic        rdy;
    int          cyc;
  } rec_t;

  rec_t mon1[$];
  rec_t mon2[$];
  rec_t exp_q[$];

  // Log every output transfer; sampled on the falling edge, completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready)
      mon1.push_back(rec_t'{{8'h00, out_data}, out_channel, out_error, out_sop, out_eop,
                            out_empty[0], in_ready, cyc});
    if (!reset && b_out_valid && b_out_ready)
      mon2.push_back(rec_t'{b_out_data, b_out_channel, b_out_error, b_out_sop, b_out_eop,
                            b_out_empty[0], b_in_ready, cyc});
  end

  task automatic send1(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em,
                       input logic ch, input logic er, output int acc);
    int n;
    acc = -1;
    in_data = d; in_sop = s; in_eop = e; in_empty = em; in_channel = ch; in_error = er;
    in_valid = 1'b1;
    n = 0;
    while (acc < 0 && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        acc = cyc;
      end
      n++;
    end
    in_valid = 1'b0;
    if (acc < 0) begin
      total++; bad++;
      $display("FAIL send1_timeout: accepted=0 required=1");
    end
  endtask

  task automatic send2(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
    int n;
    bit done;
    done = 0;
    b_in_data = d; b_in_sop = s; b_in_eop = e; b_in_empty = em;
    b_in_valid = 1'b1;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (b_in_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
      n++;
    end
    b_in_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL send2_timeout: accepted=0 required=1");
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    total++;
    if ({out_valid, out_data, out_channel, out_error, out_sop, out_eop, out_empty} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got=%h want=0",
               {out_valid, out_data, out_channel, out_error, out_sop, out_eop, out_empty});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got=%b want=1", in_ready); end
    total++;
    if (b_out_valid !== 1'b0 || b_out_data !== 16'h0 || b_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_dut2: valid=%b data=%h in_ready=%b want 0/0/1",
               b_out_valid, b_out_data, b_in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int acc;
    logic [31:0] w;
    logic [7:0] want;
    w = 32'hAABBCCDD;
    mon1.delete();
    out_ready = 1'b1;
    send1(w, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, acc);
    repeat (8) @(posedge clk); #1;
    total++;
    if (mon1.size() != 4) begin bad++; $display("FAIL basic_count: got=%0d want=4", mon1.size()); end
    for (int i = 0; i < 4 && i < mon1.size(); i++) begin
      want = 8'(w >> (24 - 8 * i));
      total++;
      if (mon1[i].data[7:0] !== want || mon1[i].sop !== (i == 0) || mon1[i].eop !== (i == 3) ||
          mon1[i].emp !== 1'b0 || mon1[i].cyc != acc + 1 + i) begin
        bad++;
        $display("FAIL basic_beat%0d: data=%h sop=%b eop=%b emp=%b cyc=%0d want data=%h sop=%b eop=%b emp=0 cyc=%0d",
                 i, mon1[i].data[7:0], mon1[i].sop, mon1[i].eop, mon1[i].emp, mon1[i].cyc,
                 want, (i == 0), (i == 3), acc + 1 + i);
      end
    end
  endtask

  task automatic test_short_eop();
    int acc;
    mon1.delete();
    out_ready = 1'b1;
    send1(32'h11223344, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, acc);
    repeat (8) @(posedge clk); #1;
    total++;
    if (mon1.size() != 2) begin bad++; $display("FAIL short_count: got=%0d want=2", mon1.size()); end
    if (mon1.size() >= 2) begin
      total++;
      if (mon1[0].data[7:0] !== 8'h11 || mon1[0].sop !== 1'b1 || mon1[0].eop !== 1'b0) begin
        bad++;
        $display("FAIL short_first: data=%h sop=%b eop=%b want 11/1/0",
                 mon1[0].data[7:0], mon1[0].sop, mon1[0].eop);
      end
      total++;
      if (mon1[1].data[7:0] !== 8'h22 || mon1[1].sop !== 1'b0 || mon1[1].eop !== 1'b1) begin
        bad++;
        $display("FAIL short_last: data=%h sop=%b eop=%b want 22/0/1",
                 mon1[1].data[7:0], mon1[1].sop, mon1[1].eop);
      end
      total++;
      if (mon1[0].rdy !== 1'b1) begin
        bad++; $display("FAIL short_in_ready: got=%b want=1", mon1[0].rdy);
      end
    end
  endtask

  task automatic test_out2();
    logic [31:0] w;
    logic [15:0] want;
    int nsym, nb, emp;
    w = 32'hA1B2C3D4;
    b_out_ready = 1'b1;
    for (int e = 0; e < 4; e++) begin
      mon2.delete();
      send2(w, 1'b1, 1'b1, 2'(e));
      repeat (6) @(posedge clk); #1;
      nsym = 4 - e;
      nb   = (nsym + 1) / 2;
      emp  = nb * 2 - nsym;
      total++;
      if (mon2.size() != nb) begin
        bad++; $display("FAIL out2_count_e%0d: got=%0d want=%0d", e, mon2.size(), nb);
      end
      for (int j = 0; j < nb && j < mon2.size(); j++) begin
        want = 16'(w >> (16 - 16 * j));
        total++;
        if (mon2[j].data !== want || mon2[j].sop !== (j == 0) || mon2[j].eop !== (j == nb - 1) ||
            mon2[j].emp !== ((j == nb - 1) ? 1'(emp) : 1'b0)) begin
          bad++;
          $display("FAIL out2_e%0d_beat%0d: data=%h sop=%b eop=%b emp=%b want data=%h sop=%b eop=%b emp=%0d",
                   e, j, mon2[j].data, mon2[j].sop, mon2[j].eop, mon2[j].emp,
                   want, (j == 0), (j == nb - 1), (j == nb - 1) ? emp : 0);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, hold, rdy_bad;
    logic [7:0] want;
    mon1.delete();
    out_ready = 1'b1;
    send1(32'h55667788, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, acc);
    hold = 0; rdy_bad = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      out_ready = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (out_valid && out_data == 8'h66) begin
        hold++;
        if (in_ready !== 1'b0) rdy_bad++;
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    total++;
    if (hold != 3) begin bad++; $display("FAIL bp_hold: got=%0d want=3", hold); end
    total++;
    if (rdy_bad != 0) begin bad++; $display("FAIL bp_in_ready: high_cycles=%0d want=0", rdy_bad); end
    total++;
    if (mon1.size() != 4) begin bad++; $display("FAIL bp_count: got=%0d want=4", mon1.size()); end
    for (int i = 0; i < 4 && i < mon1.size(); i++) begin
      want = 8'h55 + 8'(17 * i);
      total++;
      if (mon1[i].data[7:0] !== want) begin
        bad++; $display("FAIL bp_beat%0d: data=%h want=%h", i, mon1[i].data[7:0], want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] beats [3];
    int i, n;
    logic rdy;
    beats[0] = 32'h01020304; beats[1] = 32'h05060708; beats[2] = 32'h090A0B0C;
    mon1.delete();
    out_ready = 1'b1;
    in_data = beats[0]; in_sop = 1'b1; in_eop = 1'b0; in_empty = 2'd0;
    in_channel = 1'b0; in_error = 1'b0; in_valid = 1'b1;
    i = 0; n = 0;
    while (i < 3 && n < 40) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        i++;
        if (i < 3) begin
          in_data = beats[i]; in_sop = 1'b0;
          in_channel = (i == 1); in_error = (i == 1);
        end else begin
          in_valid = 1'b0;
        end
      end
      n++;
    end
    in_valid = 1'b0; in_channel = 1'b0; in_error = 1'b0;
    if (i < 3) begin
      total++; bad++; $display("FAIL b2b_timeout: accepted=%0d want=3", i);
    end
    repeat (16) @(posedge clk); #1;
    total++;
    if (mon1.size() != 12) begin bad++; $display("FAIL b2b_count: got=%0d want=12", mon1.size()); end
    for (int j = 0; j < 12 && j < mon1.size(); j++) begin
      total++;
      if (mon1[j].data[7:0] !== 8'(j + 1) || mon1[j].ch !== (j / 4 == 1) ||
          mon1[j].err !== (j / 4 == 1) || mon1[j].sop !== (j == 0) || mon1[j].eop !== 1'b0 ||
          mon1[j].cyc != mon1[0].cyc + j) begin
        bad++;
        $display("FAIL b2b_beat%0d: data=%h ch=%b err=%b sop=%b eop=%b cyc=%0d want data=%h ch=%b err=%b sop=%b eop=0 cyc=%0d",
                 j, mon1[j].data[7:0], mon1[j].ch, mon1[j].err, mon1[j].sop, mon1[j].eop,
                 mon1[j].cyc, 8'(j + 1), (j / 4 == 1), (j / 4 == 1), (j == 0), mon1[0].cyc + j);
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    mon1.delete();
    out_ready = 1'b1;
    send1(32'hDEADBEEF, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hAD) begin
      bad++; $display("FAIL rst_mid_pre: valid=%b data=%h want 1/ad", out_valid, out_data);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({out_valid, out_data, out_channel, out_error, out_sop, out_eop, out_empty} !== 14'h0 ||
        in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_zero: outs=%h in_ready=%b want 0/1",
               {out_valid, out_data, out_channel, out_error, out_sop, out_eop, out_empty}, in_ready);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    mon1.delete();
    send1(32'h0F1E2D3C, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, acc);
    repeat (8) @(posedge clk); #1;
    total++;
    if (mon1.size() != 4) begin bad++; $display("FAIL rst_mid_count: got=%0d want=4", mon1.size()); end
    if (mon1.size() >= 1) begin
      total++;
      if (mon1[0].data[7:0] !== 8'h0F || mon1[0].sop !== 1'b1 || mon1[0].ch !== 1'b0 ||
          mon1[0].cyc != acc + 1) begin
        bad++;
        $display("FAIL rst_mid_first: data=%h sop=%b ch=%b cyc=%0d want 0f/1/0/%0d",
                 mon1[0].data[7:0], mon1[0].sop, mon1[0].ch, mon1[0].cyc, acc + 1);
      end
    end
  endtask

  task automatic test_random();
    int sent, n, nsym;
    bit acc_flag;
    logic [7:0] b;
    exp_q.delete();
    mon1.delete();
    in_valid = 1'b0;
    sent = 0; n = 0; acc_flag = 0;
    while (sent < 40 && n < 3000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_data    = $urandom;
        in_sop     = 1'($urandom_range(0, 1));
        in_eop     = 1'($urandom_range(0, 1));
        in_empty   = 2'($urandom_range(0, 3));
        in_channel = 1'($urandom_range(0, 1));
        in_error   = 1'($urandom_range(0, 1));
        in_valid   = 1'b1;
      end
      @(negedge clk);
      acc_flag = in_valid && in_ready;
      if (acc_flag) begin
        nsym = in_eop ? 4 - int'(in_empty) : 4;
        for (int s = 0; s < nsym; s++) begin
          b = 8'(in_data >> (24 - 8 * s));
          exp_q.push_back(rec_t'{{8'h00, b}, in_channel, in_error, in_sop && (s == 0),
                                 in_eop && (s == nsym - 1), 1'b0, 1'b0, 0});
        end
        sent++;
      end
      @(posedge clk); #1;
      if (acc_flag) in_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (mon1.size() < exp_q.size() && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (6) @(posedge clk); #1;
    total++;
    if (sent != 40 || mon1.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count: sent=%0d got=%0d want sent=40 got=%0d", sent, mon1.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < mon1.size(); i++) begin
      total++;
      if (mon1[i].data !== exp_q[i].data || mon1[i].ch !== exp_q[i].ch ||
          mon1[i].err !== exp_q[i].err || mon1[i].sop !== exp_q[i].sop ||
          mon1[i].eop !== exp_q[i].eop || mon1[i].emp !== exp_q[i].emp) begin
        bad++;
        $display("FAIL rand_beat%0d: data=%h ch=%b err=%b sop=%b eop=%b emp=%b want data=%h ch=%b err=%b sop=%b eop=%b emp=%b",
                 i, mon1[i].data[7:0], mon1[i].ch, mon1[i].err, mon1[i].sop, mon1[i].eop, mon1[i].emp,
                 exp_q[i].data[7:0], exp_q[i].ch, exp_q[i].err, exp_q[i].sop, exp_q[i].eop, exp_q[i].emp);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_data = '0; in_channel = 1'b0; in_error = 1'b0;
    in_sop = 1'b0; in_eop = 1'b0; in_empty = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_channel = 1'b0; b_in_error = 1'b0;
    b_in_sop = 1'b0; b_in_eop = 1'b0; b_in_empty = '0; b_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_short_eop();
    test_out2();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: elapsed=2000000ns limit=2000000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
